// File: rtl/tick_timer_if.sv
// Control/status bundle between the game controller and the tick_timer block.
// master: drives sel/load/period/periodic/start/stop/pause, observes tick/active/cur_count.
// slave:  the timer side of the same signals.
interface tick_timer_if #(
    parameter int WIDTH    = 27,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [SEL_W-1:0]    sel;
    logic                load;
    logic [WIDTH-1:0]    period;
    logic                periodic;
    logic                start;
    logic                stop;
    logic                pause;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] active;
    logic [WIDTH-1:0]    cur_count;

    modport master (
        output sel, load, period, periodic, start, stop, pause,
        input  tick, active, cur_count
    );

    modport slave (
        input  sel, load, period, periodic, start, stop, pause,
        output tick, active, cur_count
    );
endinterface

// File: rtl/tick_timer.sv
// Multi-channel programmable tick generator: per-channel period, periodic/one-shot mode, start/stop.
// Ports: clk, reset (async, active-high), bus (tick_timer_if.slave: sel/load/period/periodic/
//        start/stop/pause in; tick/active registered out, cur_count combinational out).
// Optional macro TICK_TIMER_PRESCALE_EN adds a free-running prescaler (parameter PRESCALE)
// that gates which unpaused cycles count.
module tick_timer #(
    parameter int WIDTH    = 27,
    parameter int CHANNELS = 4,
`ifdef TICK_TIMER_PRESCALE_EN
    parameter int PRESCALE = 1,
`endif
    parameter int SEL_W    = 2
) (
    input  logic       clk,
    input  logic       reset,
    tick_timer_if.slave bus
);

    logic [WIDTH-1:0]    per_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] act_q;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] hit;
    logic                count_en;
    logic [WIDTH-1:0]    cur;

    // One-hot channel address; a sel beyond the last channel hits nothing,
    // which makes load/start/stop no-ops and cur_count read zero.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.sel) == i) begin
                hit[i] = 1'b1;
            end
        end
    end

`ifdef TICK_TIMER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q;
    logic            strobe;

    assign strobe = (ps_q == PS_W'(PRESCALE - 1));

    // Free-running; only reset re-aligns it, so start is not phase-aligned to the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else if (!bus.pause) begin
            ps_q <= strobe ? '0 : ps_q + PS_W'(1);
        end
    end

    assign count_en = !bus.pause && strobe;
`else
    assign count_en = !bus.pause;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                per_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            mode_q <= '0;
            act_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                tick_q[i] <= 1'b0;
                if (hit[i] && bus.stop) begin
                    act_q[i] <= 1'b0;
                    cnt_q[i] <= '0;
                end else if (hit[i] && bus.start) begin
                    cnt_q[i] <= '0;
                    act_q[i] <= 1'b1;
                end else if (act_q[i] && count_en) begin
                    // >= rather than == so a period shrunk below the running
                    // count terminates on the next counting cycle instead of wrapping.
                    if (cnt_q[i] >= per_q[i]) begin
                        tick_q[i] <= 1'b1;
                        cnt_q[i]  <= '0;
                        if (!mode_q[i]) begin
                            act_q[i] <= 1'b0;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + WIDTH'(1);
                    end
                end
                // Period/mode update is independent of the counting decision:
                // the compare on this edge still sees the old period.
                if (hit[i] && bus.load) begin
                    per_q[i]  <= bus.period;
                    mode_q[i] <= bus.periodic;
                end
            end
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
                cur = cnt_q[i];
            end
        end
    end

    assign bus.tick      = tick_q;
    assign bus.active    = act_q;
    assign bus.cur_count = cur;

endmodule
